// File: rtl/mips_exec_decode.sv
// Execute-stage decode for a MIPS subset. The opcode drives the main control
// decode, and aluop plus funct select the ALU operation. The ALU evaluates
// rs_data against rt_data or seimm. The control word, ALU code, result and
// zero flag are all registered on the same edge, so latency is one cycle.
module mips_exec_decode #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             bubble,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [WIDTH-1:0] seimm,
    output logic [8:0]       ctl,
    output logic [3:0]       aluctl,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    // Field order matches the ctl port, MSB first.
    typedef struct packed {
        logic       regdst;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic [1:0] aluop;
        logic       regwrite;
        logic       alusrc;
    } ctl_t;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NONE = 4'b1111;

    ctl_t             dec;
    logic [3:0]       alu_code;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] alu_res;
    logic             lt;

    // Main decode. A bubble clears every field, which falls through to an add.
    always_comb begin
        dec = '0;
        case (opcode)
            6'b000000: begin dec.regdst = 1'b1; dec.regwrite = 1'b1; dec.aluop = 2'b10; end
            6'b100011: begin
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
            end
            6'b101011: begin dec.memwrite = 1'b1; dec.alusrc = 1'b1; end
            6'b000100: begin dec.branch = 1'b1; dec.aluop = 2'b01; end
            6'b001000: begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; end
            default: ;
        endcase
        if (bubble)
            dec = '0;
    end

    // ALU control. R-type instructions use funct. Unknown encodings map to the null op.
    always_comb begin
        alu_code = ALU_NONE;
        case (dec.aluop)
            2'b00: alu_code = ALU_ADD;
            2'b01: alu_code = ALU_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: alu_code = ALU_ADD;
                    6'b100010: alu_code = ALU_SUB;
                    6'b100100: alu_code = ALU_AND;
                    6'b100101: alu_code = ALU_OR;
                    6'b100111: alu_code = ALU_NOR;
                    6'b101010: alu_code = ALU_SLT;
                    default:   alu_code = ALU_NONE;
                endcase
            end
            default: alu_code = ALU_NONE;
        endcase
    end

    assign opb = dec.alusrc ? seimm : rt_data;
    assign lt  = $signed(rs_data) < $signed(opb);

    // ALU datapath. Add and sub wrap modulo 2^WIDTH.
    always_comb begin
        alu_res = '0;
        case (alu_code)
            ALU_AND: alu_res = rs_data & opb;
            ALU_OR:  alu_res = rs_data | opb;
            ALU_ADD: alu_res = rs_data + opb;
            ALU_SUB: alu_res = rs_data - opb;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, lt};
            ALU_NOR: alu_res = ~(rs_data | opb);
            default: alu_res = '0;
        endcase
    end

    // Output register. Reset forces a clean null result with zero set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl    <= '0;
            aluctl <= 4'b0000;
            result <= '0;
            zero   <= 1'b1;
        end else begin
            ctl    <= dec;
            aluctl <= alu_code;
            result <= alu_res;
            zero   <= (alu_res == '0);
        end
    end

endmodule

// File: tb/tb_mips_exec_decode.sv
// Bench for mips_exec_decode. It runs directed vectors and then random
// instructions, and checks every output against an instruction-level model.
module tb_mips_exec_decode;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   opcode, funct;
    logic         bubble;
    logic [W-1:0] rs_data, rt_data, seimm;
    logic [8:0]   ctl;
    logic [3:0]   aluctl;
    logic [W-1:0] result;
    logic         zero;

    int tests = 0;
    int fails = 0;

    typedef enum {K_AND, K_OR, K_ADD, K_SUB, K_SLT, K_NOR, K_NONE} op_e;

    mips_exec_decode #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .bubble(bubble),
        .rs_data(rs_data), .rt_data(rt_data), .seimm(seimm),
        .ctl(ctl), .aluctl(aluctl), .result(result), .zero(zero)
    );

    always #5 clk = ~clk;

    // Instruction-level reference model. It classifies the instruction,
    // picks the operation and operand, and then evaluates the result.
    function automatic void model(input logic r, input logic bub, input logic [5:0] op,
                                  input logic [5:0] fn, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic [W-1:0] imm,
                                  output logic [8:0] c, output logic [3:0] ac,
                                  output logic [W-1:0] res, output logic z);
        logic       regdst = 0, branch = 0, memread = 0, memwrite = 0, memtoreg = 0;
        logic       regwrite = 0, alusrc = 0;
        logic [1:0] aluop = 2'b00;
        op_e        k = K_ADD;
        logic [W-1:0] ob;
        if (!bub) begin
            if (op == 6'd0) begin
                regdst = 1; regwrite = 1; aluop = 2'b10;
                case (fn)
                    6'h20: k = K_ADD;
                    6'h22: k = K_SUB;
                    6'h24: k = K_AND;
                    6'h25: k = K_OR;
                    6'h27: k = K_NOR;
                    6'h2a: k = K_SLT;
                    default: k = K_NONE;
                endcase
            end else if (op == 6'h23) begin
                memread = 1; memtoreg = 1; regwrite = 1; alusrc = 1;
            end else if (op == 6'h2b) begin
                memwrite = 1; alusrc = 1;
            end else if (op == 6'h04) begin
                branch = 1; aluop = 2'b01; k = K_SUB;
            end else if (op == 6'h08) begin
                regwrite = 1; alusrc = 1;
            end
        end
        c  = {regdst, branch, memread, memwrite, memtoreg, aluop, regwrite, alusrc};
        ob = alusrc ? imm : b;
        case (k)
            K_AND:   begin ac = 4'b0000; res = a & ob; end
            K_OR:    begin ac = 4'b0001; res = a | ob; end
            K_ADD:   begin ac = 4'b0010; res = W'((longint'(a) + longint'(ob)) % (64'd1 << W)); end
            K_SUB:   begin ac = 4'b0110; res = W'(longint'(a) - longint'(ob)); end
            K_SLT:   begin ac = 4'b0111; res = ($signed(a) < $signed(ob)) ? 1 : 0; end
            K_NOR:   begin ac = 4'b1100; res = ~(a | ob); end
            default: begin ac = 4'b1111; res = 0; end
        endcase
        z = (res == 0);
        if (r) begin
            c = 0; ac = 0; res = 0; z = 1;
        end
    endfunction

    // Drives one cycle of inputs, waits for the capture edge, and checks all
    // four outputs against the model.
    task automatic step(input string tag, input logic r, input logic bub,
                        input logic [5:0] op, input logic [5:0] fn,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] imm);
        logic [8:0]   ec;
        logic [3:0]   ea;
        logic [W-1:0] er;
        logic         ez;
        rst = r; bubble = bub; opcode = op; funct = fn;
        rs_data = a; rt_data = b; seimm = imm;
        model(r, bub, op, fn, a, b, imm, ec, ea, er, ez);
        @(posedge clk);
        #1;
        tests += 4;
        assert (ctl === ec) else begin
            fails++; $error("FAIL %s ctl got=%b exp=%b", tag, ctl, ec);
        end
        assert (aluctl === ea) else begin
            fails++; $error("FAIL %s aluctl got=%b exp=%b", tag, aluctl, ea);
        end
        assert (result === er) else begin
            fails++; $error("FAIL %s result got=%h exp=%h", tag, result, er);
        end
        assert (zero === ez) else begin
            fails++; $error("FAIL %s zero got=%b exp=%b", tag, zero, ez);
        end
    endtask

    // Literal spot checks that pin the model to hand-derived values.
    task automatic lit(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++; $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        logic [5:0]   ops [6] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h3f};
        logic [5:0]   fns [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h00};
        logic [5:0]   op, fn;
        logic [W-1:0] a, b, imm;

        rst = 1; bubble = 0; opcode = 0; funct = 0; rs_data = 0; rt_data = 0; seimm = 0;

        step("reset", 1, 0, 6'h00, 6'h20, 32'h7, 32'h5, 32'h0);
        lit("reset_zero", W'(zero), 1);

        step("radd", 0, 0, 6'h00, 6'h20, 32'd7, 32'd5, 32'h0);
        lit("radd_ctl", W'(ctl), W'(9'b1_0_0_0_0_10_1_0));
        lit("radd_res", result, 32'd12);
        step("slt_neg", 0, 0, 6'h00, 6'h2a, 32'hFFFF_FFFF, 32'd1, 32'h0);
        lit("slt_neg_res", result, 32'd1);
        step("sub_eq", 0, 0, 6'h00, 6'h22, 32'd3, 32'd3, 32'h0);
        step("add_wrap", 0, 0, 6'h00, 6'h20, 32'hFFFF_FFFF, 32'd1, 32'h0);
        lit("add_wrap_z", W'(zero), 1);
        step("and", 0, 0, 6'h00, 6'h24, 32'hF0F0, 32'hFF00, 32'h0);
        step("or", 0, 0, 6'h00, 6'h25, 32'hF0, 32'h0F, 32'h0);
        step("nor", 0, 0, 6'h00, 6'h27, 32'hF0, 32'h0F, 32'h0);
        step("lw", 0, 0, 6'h23, 6'h00, 32'h100, 32'h999, 32'h10);
        lit("lw_res", result, 32'h110);
        step("sw", 0, 0, 6'h2b, 6'h11, 32'h200, 32'h1, 32'hFFFF_FFFC);
        step("addi", 0, 0, 6'h08, 6'h00, 32'h5, 32'h77, 32'hFFFF_FFFB);
        step("beq_eq", 0, 0, 6'h04, 6'h00, 32'h55, 32'h55, 32'h0);
        lit("beq_eq_z", W'(zero), 1);
        step("beq_ne", 0, 0, 6'h04, 6'h00, 32'h55, 32'h54, 32'h0);
        step("bubble_lw", 0, 1, 6'h23, 6'h00, 32'h100, 32'h999, 32'h10);
        lit("bubble_res", result, 32'hA99);
        step("unk_op", 0, 0, 6'h3f, 6'h20, 32'h1, 32'h2, 32'h3);
        step("r_fn0", 0, 0, 6'h00, 6'h00, 32'h1234, 32'h5678, 32'h0);
        lit("r_fn0_aluctl", W'(aluctl), 32'hF);

        // Reset mid-stream discards the in-flight OR, and capture resumes right after.
        step("pre_rst_or", 0, 0, 6'h00, 6'h25, 32'hF0, 32'h0F, 32'h0);
        step("mid_rst", 1, 0, 6'h00, 6'h25, 32'hF0, 32'h0F, 32'h0);
        step("post_rst", 0, 0, 6'h00, 6'h22, 32'h10, 32'h3, 32'h0);

        for (int i = 0; i < 300; i++) begin
            op  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            fn  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            imm = ($urandom_range(0, 3) == 0) ? -a : 32'($signed(16'($urandom)));
            step("rand", $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
                 op, fn, a, b, imm);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
